rx_byte_assembler: RTL and testbench
====================================

// Module: rx_byte_assembler
// PURPOSE
//   USB receive bit-level stage, driven by the bit/byte timer.
//   - Takes the synchronized D+ sample and the per-bit shift_enable strobe.
//   - NRZI-decodes each sampled bit and removes stuffed bits.
//   - Assembles LSB-first bytes and hands each completed byte downstream with a one-cycle strobe.
//   - Drives the timer's count enable (bit_accept) so stuffed bits are never counted.
// PARAMETERS
//   DATA_WIDTH   8   bits per assembled word
//   STUFF_LIMIT  6   consecutive decoded 1s after which the next bit is a stuffed bit
// PORTS
//   clk           in   1           system clock, all state on rising edge
//   n_rst         in   1           asynchronous active-low reset
//   d_plus_sync   in   1           synchronized D+ line level
//   shift_enable  in   1           one-cycle strobe: sample d_plus_sync this cycle
//   rx_active     in   1           packet reception window (high from SYNC detect to EOP)
//   eop           in   1           end-of-packet detected (one-cycle pulse)
//   bit_accept    out  1           comb: shift_enable & RECEIVE & bit not stuffed (timer count_enable)
//   rx_byte       out  DATA_WIDTH  last completed byte, held until the next completes
//   byte_ready    out  1           one-cycle pulse, rx_byte updated same cycle
//   stuff_error   out  1           one-cycle pulse, stuffed-bit violation
//   align_error   out  1           one-cycle pulse, packet ended mid-byte
// BEHAVIOUR
//   Reset values: rx_byte=0, byte_ready=0, stuff_error=0, align_error=0, state=IDLE, d_prev=1 (J idle), ones_cnt=0, bit_cnt=0, shift reg=0.
//   NRZI decode
//     - dbit = (d_plus_sync == d_prev).
//     - d_prev <= d_plus_sync on EVERY shift_enable, in any state.
//   FSM: IDLE, RECEIVE
//     - IDLE -> RECEIVE when rx_active=1 (checked every cycle). Entering clears ones_cnt, bit_cnt.
//     - RECEIVE -> IDLE on eop=1 or rx_active=0.
//     - If bit_cnt!=0 when leaving RECEIVE: align_error pulses the next cycle and the partial byte is discarded (rx_byte unchanged).
//   Per shift_enable in RECEIVE
//     - If ones_cnt==STUFF_LIMIT: the bit is stuffed and dropped (no shift, bit_cnt unchanged, bit_accept=0); ones_cnt<=0.
//     - Otherwise: sr <= {dbit, sr[DATA_WIDTH-1:1]}; bit_cnt<=bit_cnt+1; ones_cnt <= dbit ? ones_cnt+1 : 0.
//   Byte completion
//     - When the accepted bit is bit number DATA_WIDTH-1: rx_byte <= {dbit, sr[DATA_WIDTH-1:1]}, byte_ready<=1, bit_cnt<=0.
//     - Latency: byte_ready is high the cycle after the final shift_enable, for exactly one cycle.
//   Boundary rules
//     - eop/rx_active drop coincident with shift_enable: exit wins; the sample is not shifted and no byte_ready is produced.
//     - shift_enable in IDLE only updates d_prev.
//     - ones_cnt saturates at STUFF_LIMIT. The stuffed-bit check runs regardless of byte boundary (a run may span bytes).
//     - Reset asserted mid-byte: everything returns to reset values asynchronously; no strobes are emitted.
//   Width rules: bit_cnt and ones_cnt are $clog2(DATA_WIDTH+1) and $clog2(STUFF_LIMIT+1) bits wide.
// CONFIGURATION
//   RX_STUFF_CHECK_EN defined
//     - A stuffed-bit slot whose dbit==1 pulses stuff_error one cycle later.
//     - The bit is still dropped, and reception continues.
//   RX_STUFF_CHECK_EN undefined
//     - stuff_error is tied 0; the stuffed bit is dropped without checking.
// TESTING
//   1 SYNC: rx_active=1; D+ samples 0,1,0,1,0,1,0,0 from d_prev=1
//     -> byte_ready once, rx_byte=0x80, align_error=0.
//   2 Stuffing: data 0xFF,0x01; six 1s then a stuffed 0 (D+ toggles)
//     -> stuffed bit dropped, bit_accept=0 on that strobe, bytes 0xFF then 0x01 reported, stuff_error=0.
//   3 Stuff violation: seven decoded 1s
//     -> with RX_STUFF_CHECK_EN, stuff_error pulses once, one cycle after the 7th sample; without it, stuff_error stays 0.
//   4 Truncation: eop after 5 accepted bits
//     -> align_error pulse, no byte_ready, rx_byte keeps its prior value, state IDLE.
//   5 Collision: eop on the same cycle as the 8th shift_enable
//     -> no byte_ready, align_error pulses (bit_cnt=7).
//   6 Reset: n_rst low mid-byte, then resend SYNC
//     -> all outputs 0 immediately; next byte decodes as 0x80.

Source files
------------

// File: rtl/rx_byte_assembler_if.sv
// Receive-side bit/byte handshake between the bit timer, the assembler and the packet layer.
interface rx_byte_assembler_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  d_plus_sync;
    logic                  shift_enable;
    logic                  rx_active;
    logic                  eop;
    logic                  bit_accept;
    logic [DATA_WIDTH-1:0] rx_byte;
    logic                  byte_ready;
    logic                  stuff_error;
    logic                  align_error;

    modport master (
        output d_plus_sync, shift_enable, rx_active, eop,
        input  bit_accept, rx_byte, byte_ready, stuff_error, align_error
    );

    modport slave (
        input  d_plus_sync, shift_enable, rx_active, eop,
        output bit_accept, rx_byte, byte_ready, stuff_error, align_error
    );
endinterface

// File: rtl/rx_byte_assembler.sv
// USB RX bit stage: NRZI decode, bit-unstuffing and LSB-first byte assembly.
// Optional RX_STUFF_CHECK_EN flags a stuffed-bit slot that decodes as 1.
module rx_byte_assembler #(
    parameter int DATA_WIDTH  = 8,
    parameter int STUFF_LIMIT = 6
) (
    input logic             clk,
    input logic             n_rst,
    rx_byte_assembler_if.slave bus
);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam int OW = $clog2(STUFF_LIMIT + 1);

    typedef enum logic {IDLE, RECEIVE} state_t;

    state_t                r_state, w_next_state;
    logic                  r_d_prev;
    logic [OW-1:0]         r_ones_cnt;
    logic [BW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_sr;
    logic [DATA_WIDTH-1:0] r_rx_byte;
    logic                  r_byte_ready;
    logic                  r_align_error;
    logic                  r_stuff_error;

    logic w_dbit, w_enter, w_exit, w_stuffed, w_sample, w_last, w_stuff_hit;

    always_comb begin
        w_next_state = r_state;
        w_enter      = 1'b0;
        w_exit       = 1'b0;
        case (r_state)
            IDLE: if (bus.rx_active) begin
                w_next_state = RECEIVE;
                w_enter      = 1'b1;
            end
            RECEIVE: if (bus.eop || !bus.rx_active) begin
                w_next_state = IDLE;
                w_exit       = 1'b1;
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_dbit    = (bus.d_plus_sync == r_d_prev);
    assign w_stuffed = (r_ones_cnt == OW'(STUFF_LIMIT));
    // A coincident packet exit takes priority over the sample on the same strobe.
    assign w_sample  = bus.shift_enable && (r_state == RECEIVE) && !w_exit;
    assign w_last    = (r_bit_cnt == BW'(DATA_WIDTH - 1));

`ifdef RX_STUFF_CHECK_EN
    assign w_stuff_hit = w_sample && w_stuffed && w_dbit;
`else
    assign w_stuff_hit = 1'b0;
`endif

    assign bus.bit_accept  = bus.shift_enable && (r_state == RECEIVE) && !w_stuffed;
    assign bus.rx_byte     = r_rx_byte;
    assign bus.byte_ready  = r_byte_ready;
    assign bus.align_error = r_align_error;
    assign bus.stuff_error = r_stuff_error;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state       <= IDLE;
            r_d_prev      <= 1'b1;
            r_ones_cnt    <= '0;
            r_bit_cnt     <= '0;
            r_sr          <= '0;
            r_rx_byte     <= '0;
            r_byte_ready  <= 1'b0;
            r_align_error <= 1'b0;
            r_stuff_error <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_byte_ready  <= 1'b0;
            r_align_error <= 1'b0;
            r_stuff_error <= w_stuff_hit;
            if (bus.shift_enable)
                r_d_prev <= bus.d_plus_sync;
            if (w_enter) begin
                r_ones_cnt <= '0;
                r_bit_cnt  <= '0;
            end
            if (w_exit) begin
                // Partial byte is dropped; rx_byte keeps the last complete one.
                r_align_error <= (r_bit_cnt != '0);
                r_bit_cnt     <= '0;
            end else if (w_sample) begin
                if (w_stuffed) begin
                    r_ones_cnt <= '0;
                end else begin
                    r_sr       <= {w_dbit, r_sr[DATA_WIDTH-1:1]};
                    r_ones_cnt <= w_dbit ? r_ones_cnt + OW'(1) : '0;
                    if (w_last) begin
                        r_rx_byte    <= {w_dbit, r_sr[DATA_WIDTH-1:1]};
                        r_byte_ready <= 1'b1;
                        r_bit_cnt    <= '0;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + BW'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_rx_byte_assembler.sv
// Directed bench for rx_byte_assembler: SYNC, stuffing, violations, truncation, collision, reset.
module tb_rx_byte_assembler;
    logic clk;
    logic n_rst;
    int   errors = 0;
    int   checks = 0;

    logic       tb_line;
    int         tb_ones;
    int         cnt_br = 0;
    int         cnt_al = 0;
    int         cnt_se = 0;
    logic [7:0] mon_last = 8'h00;
    logic [7:0] mon_prev = 8'h00;

    rx_byte_assembler_if #(.DATA_WIDTH(8)) bus ();

    rx_byte_assembler #(.DATA_WIDTH(8), .STUFF_LIMIT(6)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.byte_ready) begin
            cnt_br   <= cnt_br + 1;
            mon_prev <= mon_last;
            mon_last <= bus.rx_byte;
        end
        if (bus.align_error) cnt_al <= cnt_al + 1;
        if (bus.stuff_error) cnt_se <= cnt_se + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One strobe at a raw line level; optionally checks bit_accept while the strobe is up.
    task automatic send_raw(input logic lvl, input bit chk, input logic exp_acc, input string nm);
        bus.d_plus_sync  = lvl;
        bus.shift_enable = 1'b1;
        #2;
        if (chk) begin
            checks++;
            if (bus.bit_accept !== exp_acc) begin
                errors++;
                $display("FAIL %s bit_accept got=%b exp=%b", nm, bus.bit_accept, exp_acc);
            end
        end
        @(posedge clk);
        #1;
        bus.shift_enable = 1'b0;
        tb_line = lvl;
    endtask

    // NRZI-encode one data bit; with stuff=1 a 0 is inserted after six 1s.
    task automatic send_data(input logic b, input bit stuff);
        send_raw(b ? tb_line : ~tb_line, 1'b0, 1'b0, "data");
        tb_ones = b ? tb_ones + 1 : 0;
        if (stuff && tb_ones == 6) begin
            send_raw(~tb_line, 1'b1, 1'b0, "stuffed_slot");
            tb_ones = 0;
        end
    endtask

    task automatic start_packet();
        bus.rx_active = 1'b1;
        tb_ones = 0;
        tick(1);
    endtask

    task automatic end_packet();
        bus.rx_active = 1'b0;
        tick(3);
    endtask

    task automatic send_sync(output logic ready_at_last);
        logic [7:0] raw;
        raw = 8'b0010_1010;
        for (int i = 0; i < 8; i++) send_raw(raw[i], 1'b1, 1'b1, "sync_accept");
        ready_at_last = bus.byte_ready;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.rx_byte !== 8'h00 || bus.byte_ready !== 1'b0 || bus.align_error !== 1'b0 || bus.stuff_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got byte=%h br=%b al=%b se=%b exp all 0",
                     bus.rx_byte, bus.byte_ready, bus.align_error, bus.stuff_error);
        end
        n_rst = 1'b1;
        tick(2);
        send_raw(1'b1, 1'b1, 1'b0, "idle_no_accept");
    endtask

    task automatic test_sync();
        int b0;
        int a0;
        logic rdy;
        b0 = cnt_br; a0 = cnt_al;
        start_packet();
        send_sync(rdy);
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL sync_latency byte_ready got=%b exp=1", rdy); end
        checks++;
        if (bus.rx_byte !== 8'h80) begin errors++; $display("FAIL sync_byte got=%h exp=80", bus.rx_byte); end
        end_packet();
        checks++;
        if (cnt_br - b0 != 1) begin errors++; $display("FAIL sync_ready_count got=%0d exp=1", cnt_br - b0); end
        checks++;
        if (cnt_al - a0 != 0) begin errors++; $display("FAIL sync_align got=%0d exp=0", cnt_al - a0); end
    endtask

    task automatic test_stuffing();
        int b0;
        int s0;
        logic [15:0] data;
        b0 = cnt_br; s0 = cnt_se;
        data = 16'h01FF;
        start_packet();
        for (int i = 0; i < 16; i++) send_data(data[i], 1'b1);
        tick(1);
        checks++;
        if (cnt_br - b0 != 2) begin errors++; $display("FAIL stuff_ready_count got=%0d exp=2", cnt_br - b0); end
        checks++;
        if (mon_prev !== 8'hFF || mon_last !== 8'h01) begin
            errors++;
            $display("FAIL stuff_bytes got=%h,%h exp=ff,01", mon_prev, mon_last);
        end
        checks++;
        if (cnt_se - s0 != 0) begin errors++; $display("FAIL stuff_no_error got=%0d exp=0", cnt_se - s0); end
        end_packet();
    endtask

    task automatic test_stuff_violation();
        int s0;
        int b0;
        logic exp_se;
`ifdef RX_STUFF_CHECK_EN
        exp_se = 1'b1;
`else
        exp_se = 1'b0;
`endif
        s0 = cnt_se; b0 = cnt_br;
        start_packet();
        for (int i = 0; i < 6; i++) send_data(1'b1, 1'b0);
        send_raw(tb_line, 1'b1, 1'b0, "violation_accept");
        checks++;
        if (bus.stuff_error !== exp_se) begin
            errors++;
            $display("FAIL violation_pulse got=%b exp=%b", bus.stuff_error, exp_se);
        end
        tick(2);
        checks++;
        if (cnt_se - s0 != (exp_se ? 1 : 0)) begin
            errors++;
            $display("FAIL violation_count got=%0d exp=%0d", cnt_se - s0, exp_se ? 1 : 0);
        end
        checks++;
        if (cnt_br - b0 != 0) begin errors++; $display("FAIL violation_no_byte got=%0d exp=0", cnt_br - b0); end
        end_packet();
    endtask

    task automatic test_truncation();
        int b0;
        int a0;
        b0 = cnt_br; a0 = cnt_al;
        start_packet();
        for (int i = 0; i < 5; i++) send_data(1'b0, 1'b1);
        bus.eop = 1'b1;
        bus.rx_active = 1'b0;
        tick(1);
        bus.eop = 1'b0;
        checks++;
        if (bus.align_error !== 1'b1) begin errors++; $display("FAIL trunc_align got=%b exp=1", bus.align_error); end
        tick(2);
        checks++;
        if (cnt_al - a0 != 1) begin errors++; $display("FAIL trunc_align_count got=%0d exp=1", cnt_al - a0); end
        checks++;
        if (cnt_br - b0 != 0 || bus.rx_byte !== 8'h01) begin
            errors++;
            $display("FAIL trunc_hold got ready=%0d byte=%h exp 0,01", cnt_br - b0, bus.rx_byte);
        end
        // A strobe now must be ignored by an idle assembler.
        send_raw(~tb_line, 1'b1, 1'b0, "trunc_idle_accept");
    endtask

    task automatic test_collision();
        int b0;
        int a0;
        logic [7:0] data;
        b0 = cnt_br; a0 = cnt_al;
        data = 8'hD5;
        start_packet();
        for (int i = 0; i < 7; i++) send_data(data[i], 1'b1);
        bus.eop = 1'b1;
        bus.rx_active = 1'b0;
        send_data(data[7], 1'b0);
        bus.eop = 1'b0;
        checks++;
        if (bus.byte_ready !== 1'b0 || bus.align_error !== 1'b1) begin
            errors++;
            $display("FAIL collision_strobes got br=%b al=%b exp br=0 al=1", bus.byte_ready, bus.align_error);
        end
        tick(2);
        checks++;
        if (cnt_br - b0 != 0 || cnt_al - a0 != 1 || bus.rx_byte !== 8'h01) begin
            errors++;
            $display("FAIL collision_counts got br=%0d al=%0d byte=%h exp 0,1,01", cnt_br - b0, cnt_al - a0, bus.rx_byte);
        end
    endtask

    task automatic test_reset_midbyte();
        int a0;
        int b0;
        logic rdy;
        start_packet();
        for (int i = 0; i < 3; i++) send_data(1'b1, 1'b1);
        #3;
        n_rst = 1'b0;
        #1;
        checks++;
        if (bus.rx_byte !== 8'h00 || bus.byte_ready !== 1'b0 || bus.align_error !== 1'b0 || bus.stuff_error !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs got byte=%h br=%b al=%b se=%b exp all 0",
                     bus.rx_byte, bus.byte_ready, bus.align_error, bus.stuff_error);
        end
        bus.rx_active = 1'b0;
        tick(1);
        a0 = cnt_al;
        n_rst = 1'b1;
        tb_line = 1'b1;
        tick(1);
        b0 = cnt_br;
        start_packet();
        send_sync(rdy);
        checks++;
        if (rdy !== 1'b1 || bus.rx_byte !== 8'h80) begin
            errors++;
            $display("FAIL post_reset_sync got ready=%b byte=%h exp 1,80", rdy, bus.rx_byte);
        end
        end_packet();
        checks++;
        if (cnt_al - a0 != 0 || cnt_br - b0 != 1) begin
            errors++;
            $display("FAIL post_reset_counts got al=%0d br=%0d exp 0,1", cnt_al - a0, cnt_br - b0);
        end
    endtask

    initial begin
        n_rst            = 1'b0;
        bus.d_plus_sync  = 1'b1;
        bus.shift_enable = 1'b0;
        bus.rx_active    = 1'b0;
        bus.eop          = 1'b0;
        tb_line          = 1'b1;
        tb_ones          = 0;
        tick(2);
        test_reset();
        test_sync();
        test_stuffing();
        test_stuff_violation();
        test_truncation();
        test_collision();
        test_reset_midbyte();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
